// File: rtl/ex_alu_multicycle.sv
// EX-stage ALU: single-cycle add/sub/and/or plus an iterative shift-add multiplier that stalls the pipeline.
// Optional build macro MULT_EARLY_EXIT_EN: finish the multiply once the remaining multiplier bits are zero.
module ex_alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             stall_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] mplier_next_s;
  logic [WIDTH-1:0] op_res_s;
  logic [WIDTH-1:0] mux_s;
  logic             is_mult_s;
  logic             issue_s;
  logic             last_s;

  // Multiplier datapath step and single-cycle operation results
  always_comb begin
    is_mult_s     = (ALUCtrl_i == 3'b001);
    issue_s       = (state_r == IDLE) && valid_i && !flush_i && is_mult_s;
    acc_next_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    mplier_next_s = mplier_r >> 1;
`ifdef MULT_EARLY_EXIT_EN
    last_s        = (cnt_r == CW'(WIDTH - 1)) || (mplier_next_s == {WIDTH{1'b0}});
`else
    last_s        = (cnt_r == CW'(WIDTH - 1));
`endif
    case (ALUCtrl_i)
      3'b000:  op_res_s = data1_i + data2_i;
      3'b010:  op_res_s = data1_i - data2_i;
      3'b011:  op_res_s = data1_i & data2_i;
      3'b100:  op_res_s = data1_i | data2_i;
      default: op_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Output select; reset gates data_o so it reads zero while rst_i is low
  always_comb begin
    if (state_r == DONE) begin
      mux_s = res_r;
    end else if (is_mult_s) begin
      mux_s = acc_r;
    end else begin
      mux_s = op_res_s;
    end
    data_o  = rst_i ? mux_s : {WIDTH{1'b0}};
    zero_o  = (data_o == {WIDTH{1'b0}});
    stall_o = rst_i && !flush_i && (issue_s || (state_r == BUSY));
  end

  // Multiply sequencer: flush returns to IDLE without touching the last result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= IDLE;
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      res_r    <= {WIDTH{1'b0}};
    end else if (flush_i) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            mcand_r  <= data1_i;
            mplier_r <= data2_i;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
`ifdef MULT_EARLY_EXIT_EN
            if (data2_i == {WIDTH{1'b0}}) begin
              res_r   <= {WIDTH{1'b0}};
              state_r <= DONE;
            end else begin
              state_r <= BUSY;
            end
`else
            state_r  <= BUSY;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_next_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            res_r   <= acc_next_s;
            state_r <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_multicycle.sv
// Self-checking bench for ex_alu_multicycle: vector table for single-cycle ops, scoreboard for multiplies.
// Stall-window expectations follow MULT_EARLY_EXIT_EN when the bench is built with it.
module tb_ex_alu_multicycle;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        flush_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    string       name;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  ex_alu_multicycle #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .data_o(data_o), .zero_o(zero_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int exp_stalls(input logic [31:0] b);
    int h;
`ifdef MULT_EARLY_EXIT_EN
    h = -1;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return 2 + h;
`else
    h = 0;
    if (b[0] === 1'bx) h = 1;
    return 33 + h;
`endif
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    valid_i = v; flush_i = 1'b0; ALUCtrl_i = op; data1_i = a; data2_i = b;
    #1;
  endtask

  // Issue one multiply, count the stall window, then compare against the scoreboard
  task automatic run_mult(input string nm, input logic [31:0] a, input logic [31:0] b);
    int stalls;
    int cycles;
    logic [31:0] exp;
    sb.push_back(a * b);
    drive(1'b1, 3'b001, a, b);
    stalls = 0;
    cycles = 0;
    while (stall_o && cycles < 100) begin
      stalls++;
      @(negedge clk_i);
      #1;
      cycles++;
    end
    chk({nm, "_stalls"}, stalls, exp_stalls(b));
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk({nm, "_data"}, data_o, exp);
      chk({nm, "_zero"}, {31'd0, zero_o}, {31'd0, exp == 32'd0});
    end else begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{"add_7_5",    1'b1, 3'b000, 32'd7,          32'd5,          32'd12,         1'b0};
    vecs[1] = '{"sub_5_5",    1'b1, 3'b010, 32'd5,          32'd5,          32'd0,          1'b1};
    vecs[2] = '{"and",        1'b1, 3'b011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    vecs[3] = '{"or",         1'b1, 3'b100, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0};
    vecs[4] = '{"add_wrap",   1'b1, 3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    vecs[5] = '{"sub_wrap",   1'b1, 3'b010, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[6] = '{"rsv_101",    1'b1, 3'b101, 32'd3,          32'd4,          32'd0,          1'b1};
    vecs[7] = '{"rsv_111",    1'b1, 3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[8] = '{"bubble_add", 1'b0, 3'b000, 32'd20,         32'd22,         32'd42,         1'b0};
    vecs[9] = '{"sub_neg",    1'b1, 3'b010, 32'd3,          32'd10,         32'hFFFF_FFF9,  1'b0};

    rst_i = 1'b0; valid_i = 1'b1; flush_i = 1'b0; ALUCtrl_i = 3'b000;
    data1_i = 32'd7; data2_i = 32'd5;
    #12;
    chk("rst_data", data_o, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd1);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    valid_i = 1'b0;

    // T1: single-cycle ops
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_data"}, data_o, vecs[i].exp);
      chk({vecs[i].name, "_zero"}, {31'd0, zero_o}, {31'd0, vecs[i].exp_zero});
      chk({vecs[i].name, "_stall"}, {31'd0, stall_o}, 32'd0);
    end

    // T2: timing, single-cycle result visibility, wrap
    run_mult("mul_3_7", 32'd3, 32'd7);
    drive(1'b1, 3'b000, 32'd100, 32'd1);
    chk("after_done_add", data_o, 32'd101);
    chk("after_done_stall", {31'd0, stall_o}, 32'd0);
    run_mult("mul_wrap", 32'hFFFF_FFFF, 32'd2);

    // T3: back-to-back
    run_mult("b2b_first", 32'd6, 32'd7);
    run_mult("b2b_second", 32'h0001_0000, 32'h0001_0000);

    // T4: flush at BUSY cycle 10
    drive(1'b1, 3'b001, 32'd5, 32'hFFFF_FFFF);
    chk("flush_issue_stall", {31'd0, stall_o}, 32'd1);
    repeat (9) begin
      @(negedge clk_i);
    end
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    drive(1'b1, 3'b000, 32'd1, 32'd1);
    chk("flush_add", data_o, 32'd2);
    chk("flush_add_stall", {31'd0, stall_o}, 32'd0);

    // flush beats issue in IDLE
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; ALUCtrl_i = 3'b001; data1_i = 32'd3; data2_i = 32'd3;
    #1;
    chk("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    drive(1'b1, 3'b000, 32'd4, 32'd4);
    chk("flush_idle_next", data_o, 32'd8);
    chk("flush_idle_next_stall", {31'd0, stall_o}, 32'd0);

    // bubble with mult code
    drive(1'b0, 3'b001, 32'd9, 32'd9);
    chk("bubble_mult_stall", {31'd0, stall_o}, 32'd0);
    drive(1'b1, 3'b000, 32'd2, 32'd2);
    chk("bubble_then_add", data_o, 32'd4);
    chk("bubble_then_stall", {31'd0, stall_o}, 32'd0);

    // T5: async reset mid-mult
    drive(1'b1, 3'b001, 32'd7, 32'd9);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("amid_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("amid_rst_data", data_o, 32'd0);
    chk("amid_rst_zero", {31'd0, zero_o}, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i = 1'b1;
    run_mult("post_rst_2_3", 32'd2, 32'd3);

    // T6: early-exit corner operands
    run_mult("ee_9_2", 32'd9, 32'd2);
    run_mult("ee_9_0", 32'd9, 32'd0);
    drive(1'b0, 3'b001, 32'd9, 32'd2);
    chk("ee_bubble_stall", {31'd0, stall_o}, 32'd0);

    @(negedge clk_i);
    valid_i = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
